// File: rtl/macguffin_cipher_core.sv
// Iterative MacGuffin block-cipher datapath: one unbalanced-Feistel round per clock.
// A block comes in on the s_axis slave port, runs round_num rounds with live round
// keys, and the result is held on the m_axis master port until it is accepted.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   decrypt         mode (0 encrypt, 1 decrypt), sampled on the input handshake
//   round_keys      round_num x 48-bit round keys, entry read in the cycle it is used
//   s_axis_*        input block stream (tdata/tvalid/tready)
//   m_axis_*        result block stream (tdata/tvalid/tready)
//   busy            high while a block is running or waiting to be delivered
module macguffin_cipher_core #(
  parameter int unsigned round_num  = 32,
  parameter int unsigned block_size = 64
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     decrypt,
  input  logic [round_num-1:0][block_size*3/4-1:0] round_keys,
  input  logic [block_size-1:0]                    s_axis_tdata,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  output logic [block_size-1:0]                    m_axis_tdata,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic                                     busy
);

  localparam int unsigned KEY_W = block_size * 3 / 4;
  localparam int unsigned CNT_W = $clog2(round_num);
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(round_num - 1);

  // DES S-box rows (S1..S8, rows 0..3); column 0 sits in the top nibble.
  // A MacGuffin S-box is the DES box with only the outer two output bits kept.
  localparam logic [63:0] DES_ROW [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // Input bit positions per S-box, one nibble each, first entry in the top nibble:
  // two bits from a, two from b, two from c.
  localparam logic [23:0] SBITS [8] = '{
    24'h2569BD, 24'h147A8E, 24'h368D0F, 24'hCE124A,
    24'h0A3E6C, 24'h78CF15, 24'h9F5B27, 24'hBD0439
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [block_size-1:0] blk_q, blk_d;
  logic                  dec_q, dec_d;

  logic [CNT_W-1:0]      key_idx;
  logic [KEY_W-1:0]      rk;
  logic [15:0]           w0, w1, w2, w3;
  logic [15:0]           fa, fb, fc, f_out;
  logic [block_size-1:0] round_res;

  // Decrypt walks the keys backwards; round_num is a power of two so ~cnt = last-cnt.
  assign key_idx = dec_q ? ~cnt_q : cnt_q;
  assign rk      = round_keys[key_idx];

  assign {w0, w1, w2, w3} = blk_q;

  // One shared F: encrypt feeds W1..W3, decrypt feeds W0..W2.
  assign fa = (dec_q ? w0 : w1) ^ rk[47:32];
  assign fb = (dec_q ? w1 : w2) ^ rk[31:16];
  assign fc = (dec_q ? w2 : w3) ^ rk[15:0];

  // F(a,b,c): eight 6->2 S-boxes, box g drives output bits [2g+1:2g].
  for (genvar g = 0; g < 8; g++) begin : g_sbox
    localparam logic [23:0] SB = SBITS[g];
    logic [5:0]  idx;
    logic [63:0] row;
    logic [5:0]  lo;

    assign idx = {fc[SB[3:0]], fc[SB[7:4]], fb[SB[11:8]], fb[SB[15:12]],
                  fa[SB[19:16]], fa[SB[23:20]]};
    // DES addressing: outer index bits pick the row, inner four the column.
    assign row = DES_ROW[{3'(g), idx[5], idx[0]}];
    assign lo  = {~idx[4:1], 2'b00};
    assign f_out[2*g+1] = row[lo | 6'd3];
    assign f_out[2*g]   = row[lo];
  end

  assign round_res = dec_q ? {w3 ^ f_out, w0, w1, w2}
                           : {w1, w2, w3, w0 ^ f_out};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      dec_q   <= dec_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    dec_d   = dec_q;
    unique case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          blk_d   = s_axis_tdata;
          dec_d   = decrypt;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        blk_d = round_res;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_RND) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (m_axis_tready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are pure decodes of the registered state.
  assign s_axis_tready = (state_q == IDLE);
  assign m_axis_tvalid = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign m_axis_tdata  = blk_q;

endmodule

// File: tb/tb_macguffin_cipher_core.sv
// Directed bench for macguffin_cipher_core: reset, latency, round trip,
// back-pressure, key sensitivity, mid-run reset/key change and back-to-back flow.
module tb_macguffin_cipher_core;

  localparam int unsigned RN = 32;
  localparam logic [63:0] PT = 64'h0123_4567_89AB_CDEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              decrypt;
  logic [RN-1:0][47:0] rk;
  logic [63:0]       s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [63:0]       m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [63:0] des_t [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  int sb_t [8][6] = '{
    '{2, 5, 6, 9, 11, 13}, '{1, 4, 7, 10, 8, 14}, '{3, 6, 8, 13, 0, 15}, '{12, 14, 1, 2, 4, 10},
    '{0, 10, 3, 14, 6, 12}, '{7, 8, 12, 15, 1, 5}, '{9, 15, 5, 11, 2, 7}, '{11, 13, 0, 4, 3, 9}
  };

  macguffin_cipher_core #(.round_num(RN), .block_size(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .decrypt       (decrypt),
    .round_keys    (rk),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
    logic [15:0] r;
    r = '0;
    for (int s = 0; s < 8; s++) begin
      int idx, row, col;
      logic [63:0] line;
      logic [3:0] v;
      idx = 32'(a[sb_t[s][0]])        | (32'(a[sb_t[s][1]]) << 1) |
            (32'(b[sb_t[s][2]]) << 2) | (32'(b[sb_t[s][3]]) << 3) |
            (32'(c[sb_t[s][4]]) << 4) | (32'(c[sb_t[s][5]]) << 5);
      row  = ((idx >> 5) & 1) * 2 + (idx & 1);
      col  = (idx >> 1) & 15;
      line = des_t[s * 4 + row];
      v    = 4'(line >> (4 * (15 - col)));
      r[2*s+1] = v[3];
      r[2*s]   = v[0];
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_cipher(input logic [63:0] blk,
                                             input logic [RN-1:0][47:0] k, input logic dec);
    logic [15:0] x0, x1, x2, x3, t;
    logic [47:0] kk;
    {x0, x1, x2, x3} = blk;
    for (int i = 0; i < RN; i++) begin
      if (!dec) begin
        kk = k[i];
        t  = x0 ^ ref_f(x1 ^ kk[47:32], x2 ^ kk[31:16], x3 ^ kk[15:0]);
        x0 = x1; x1 = x2; x2 = x3; x3 = t;
      end else begin
        kk = k[RN-1-i];
        t  = x3 ^ ref_f(x0 ^ kk[47:32], x1 ^ kk[31:16], x2 ^ kk[15:0]);
        x3 = x2; x2 = x1; x1 = x0; x0 = t;
      end
    end
    return {x0, x1, x2, x3};
  endfunction

  task automatic set_std_keys();
    for (int i = 0; i < RN; i++) begin
      logic [3:0] n;
      n = 4'(i);
      rk[i] = {16'(16'h1111 * n), 16'hA5A5, 16'h5A5A};
    end
  endtask

  // Present one block; returns at the first negedge after the handshake edge.
  task automatic send(input logic [63:0] blk, input logic dec);
    int n;
    n = 0;
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      err_cnt++;
      $display("FAIL send_timeout s_axis_tready got %b want 1", s_tready);
    end
    s_tdata  = blk;
    decrypt  = dec;
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  // Wait for m_axis_tvalid; lat counts negedges since the handshake edge.
  task automatic wait_out(output int lat, output logic [63:0] data);
    lat = 1;
    while (!m_tvalid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    data = m_tdata;
    if (!m_tvalid) begin
      err_cnt++;
      $display("FAIL out_timeout m_axis_tvalid got %b want 1", m_tvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; decrypt = 1'b0; m_tready = 1'b1;
    set_std_keys();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vec_cnt++; if (s_tready !== 1'b1) begin err_cnt++; $display("FAIL rst_tready got %b want 1", s_tready); end
    vec_cnt++; if (m_tvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
    vec_cnt++; if (busy !== 1'b0)     begin err_cnt++; $display("FAIL rst_busy got %b want 0", busy); end
    vec_cnt++; if (m_tdata !== 64'h0) begin err_cnt++; $display("FAIL rst_tdata got %h want 0", m_tdata); end
  endtask

  task automatic test_encrypt(output logic [63:0] ct);
    int lat;
    logic [63:0] exp;
    set_std_keys();
    m_tready = 1'b1;
    exp = ref_cipher(PT, rk, 1'b0);
    send(PT, 1'b0);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL enc_busy got %b want 1", busy); end
    wait_out(lat, ct);
    vec_cnt++; if (lat !== 33) begin err_cnt++; $display("FAIL enc_latency got %0d want 33", lat); end
    vec_cnt++; if (ct !== exp) begin err_cnt++; $display("FAIL enc_data got %h want %h", ct, exp); end
    @(negedge clk);
    vec_cnt++; if (m_tvalid !== 1'b0) begin err_cnt++; $display("FAIL enc_tvalid_width got %b want 0", m_tvalid); end
    vec_cnt++; if (s_tready !== 1'b1) begin err_cnt++; $display("FAIL enc_ready_after got %b want 1", s_tready); end
  endtask

  task automatic test_roundtrip(input logic [63:0] ct);
    int lat;
    logic [63:0] got, blk, exp;
    send(ct, 1'b1);
    wait_out(lat, got);
    vec_cnt++; if (got !== PT) begin err_cnt++; $display("FAIL dec_std got %h want %h", got, PT); end
    @(negedge clk);
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < RN; i++) rk[i] = 48'({$urandom(), $urandom()});
      blk = {$urandom(), $urandom()};
      exp = ref_cipher(blk, rk, 1'b0);
      send(blk, 1'b0);
      decrypt = 1'b1;  // flipping mode mid-run must not matter
      wait_out(lat, got);
      vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL rand_enc[%0d] got %h want %h", n, got, exp); end
      @(negedge clk);
      send(got, 1'b1);
      decrypt = 1'b0;
      wait_out(lat, got);
      vec_cnt++; if (got !== blk) begin err_cnt++; $display("FAIL rand_dec[%0d] got %h want %h", n, got, blk); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] exp, got;
    set_std_keys();
    m_tready = 1'b0;
    exp = ref_cipher(64'hDEAD_BEEF_0BAD_F00D, rk, 1'b0);
    send(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    wait_out(lat, got);
    for (int i = 0; i < 10; i++) begin
      vec_cnt++;
      if (m_tdata !== exp || m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
        err_cnt++;
        $display("FAIL bp_hold[%0d] got data=%h vld=%b rdy=%b want data=%h vld=1 rdy=0",
                 i, m_tdata, m_tvalid, s_tready, exp);
      end
      @(negedge clk);
    end
    m_tready = 1'b1;
    @(negedge clk);
    vec_cnt++; if (s_tready !== 1'b1) begin err_cnt++; $display("FAIL bp_release_ready got %b want 1", s_tready); end
    vec_cnt++; if (m_tvalid !== 1'b0) begin err_cnt++; $display("FAIL bp_release_valid got %b want 0", m_tvalid); end
  endtask

  task automatic test_zero_and_last_key();
    int lat;
    logic [63:0] exp, got, first;
    for (int i = 0; i < RN; i++) rk[i] = '0;
    exp = ref_cipher(64'h0, rk, 1'b0);
    send(64'h0, 1'b0);
    wait_out(lat, first);
    vec_cnt++; if (first !== exp) begin err_cnt++; $display("FAIL zero_data got %h want %h", first, exp); end
    @(negedge clk);
    rk[RN-1] = 48'h8000_0000_0001;
    exp = ref_cipher(64'h0, rk, 1'b0);
    send(64'h0, 1'b0);
    wait_out(lat, got);
    vec_cnt++; if (got === first) begin err_cnt++; $display("FAIL last_key_used got %h want not %h", got, first); end
    vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL last_key_data got %h want %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_key_change_midrun();
    int lat;
    logic [63:0] exp, got;
    logic [RN-1:0][47:0] kexp;
    set_std_keys();
    kexp = rk;
    kexp[10] = 48'h1357_9BDF_2468;
    exp = ref_cipher(PT, kexp, 1'b0);
    send(PT, 1'b0);
    repeat (4) @(negedge clk);  // rounds 0..3 done, round 4 pending
    rk[2]  = 48'hFFFF_FFFF_FFFF;  // already consumed: no effect
    rk[10] = 48'h1357_9BDF_2468;  // still ahead: takes effect
    wait_out(lat, got);
    vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL live_keys got %h want %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int lat;
    logic [63:0] exp, got;
    bit seen;
    set_std_keys();
    send(64'h1111_2222_3333_4444, 1'b0);
    repeat (17) @(negedge clk);  // round 17 is next
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++; if (m_tvalid !== 1'b0) begin err_cnt++; $display("FAIL midrst_tvalid got %b want 0", m_tvalid); end
    vec_cnt++; if (s_tready !== 1'b1) begin err_cnt++; $display("FAIL midrst_tready got %b want 1", s_tready); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_tvalid) seen = 1'b1;
      @(negedge clk);
    end
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL midrst_ghost_output got %b want 0", seen); end
    // Reset coincident with a handshake discards that block too.
    s_tdata = 64'hAAAA_BBBB_CCCC_DDDD; s_tvalid = 1'b1; rst = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0; rst = 1'b0;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_hs_busy got %b want 0", busy); end
    exp = ref_cipher(PT, rk, 1'b0);
    send(PT, 1'b0);
    wait_out(lat, got);
    vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL post_rst_data got %h want %h", got, exp); end
    vec_cnt++; if (lat !== 33) begin err_cnt++; $display("FAIL post_rst_latency got %0d want 33", lat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] blks [3];
    logic [63:0] exp [3];
    int hs [3];
    int cyc, in_i, out_i;
    set_std_keys();
    m_tready = 1'b1;
    blks[0] = 64'h0000_0000_0000_0001;
    blks[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    blks[2] = 64'h8001_4002_2004_1008;
    for (int i = 0; i < 3; i++) begin
      exp[i] = ref_cipher(blks[i], rk, 1'b0);
      hs[i]  = 0;
    end
    cyc = 0; in_i = 0; out_i = 0;
    decrypt = 1'b0;
    s_tdata = blks[0];
    s_tvalid = 1'b1;
    while (out_i < 3 && cyc < 400) begin
      if (m_tvalid) begin
        vec_cnt++;
        if (m_tdata !== exp[out_i]) begin
          err_cnt++;
          $display("FAIL b2b_data[%0d] got %h want %h", out_i, m_tdata, exp[out_i]);
        end
        out_i++;
      end
      if (s_tready && in_i < 3) begin
        s_tdata  = blks[in_i];
        hs[in_i] = cyc;
        in_i++;
      end
      @(negedge clk);
      cyc++;
    end
    s_tvalid = 1'b0;
    vec_cnt++; if (out_i !== 3) begin err_cnt++; $display("FAIL b2b_count got %0d want 3", out_i); end
    vec_cnt++; if (hs[1] - hs[0] !== 34) begin err_cnt++; $display("FAIL b2b_gap01 got %0d want 34", hs[1] - hs[0]); end
    vec_cnt++; if (hs[2] - hs[1] !== 34) begin err_cnt++; $display("FAIL b2b_gap12 got %0d want 34", hs[2] - hs[1]); end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] ct;
    test_reset();
    test_encrypt(ct);
    test_roundtrip(ct);
    test_backpressure();
    test_zero_and_last_key();
    test_key_change_midrun();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/macguffin_cipher_core.md
Name: macguffin_cipher_core

Overview:
- Iterative MacGuffin block-cipher datapath. Takes one 64-bit block on an AXI-Stream slave port and runs round_num unbalanced-Feistel rounds, one per clock, using the externally supplied 48-bit round keys.
- Returns the result on an AXI-Stream master port.
- It is the responder to the key-schedule block: key setup streams blocks into this core and reads the results back.
- The same core also serves bulk encryption and decryption once key_ready is set.

Parameters:
- round_num, 32, number of rounds; must be a power of two, >= 2.
- block_size, 64, block width; fixed at 64 for MacGuffin (16-bit words, 48-bit round key).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- decrypt  input  1  mode; 0 = encrypt, 1 = decrypt. Sampled on the s_axis handshake cycle.
- round_keys  input  [block_size*3/4-1:0] x round_num  round-key array. Read live: entry i is used in the cycle round i executes.
- s_axis_tdata  input  block_size  input block.
- s_axis_tvalid  input  1  input valid.
- s_axis_tready  output  1  core can accept a block.
- m_axis_tdata  output  block_size  result block.
- m_axis_tvalid  output  1  result valid.
- m_axis_tready  input  1  downstream accepts the result.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Word map: W0=tdata[63:48], W1=[47:32], W2=[31:16], W3=[15:0].
- Round-key map: k0=rk[47:32], k1=[31:16], k2=[15:0].
- F(a,b,c) is the standard MacGuffin 48->16 function: 8 S-boxes of 6->2 bits, bit selection per the MacGuffin definition. It is implemented as combinational logic inside this block.
- Encrypt round i (i = 0..round_num-1, key round_keys[i]): {W0,W1,W2,W3} <= {W1, W2, W3, W0 ^ F(W1^k0, W2^k1, W3^k2)}.
- Decrypt round j (key round_keys[round_num-1-j]): {W0,W1,W2,W3} <= {W3 ^ F(W0^k0, W1^k1, W2^k2), W0, W1, W2}. This is the exact inverse of the encrypt round.
- No final swap; the block register after the last round is the output.
- FSM states:
  - IDLE: s_axis_tready=1. On s_axis_tvalid, latch tdata into the block register, latch decrypt, clear the counter, go to RUN.
  - RUN: s_axis_tready=0. One round per cycle; counter increments. On counter==round_num-1, perform the final round and go to DONE. The counter wraps to 0 naturally.
  - DONE: m_axis_tvalid=1, m_axis_tdata = block register, held stable until m_axis_tready. On the handshake, go to IDLE.
- s_axis_tready and m_axis_tvalid are combinational decodes of the registered state, so they are glitch-free and independent of same-cycle inputs.
- Latency: input handshake at cycle T; rounds execute in T+1..T+round_num; m_axis_tvalid=1 from cycle T+round_num+1.
- Throughput: one block per round_num+2 cycles with m_axis_tready tied high.
- Back-pressure: DONE holds indefinitely. No input is accepted while busy.
- s_axis_tvalid may drop in IDLE without effect.
- Changing decrypt outside the handshake cycle has no effect on a block in flight.
- round_keys changing mid-run is legal: each round uses the value present in its own cycle. Key setup relies on this.
- Reset values: state=IDLE, counter=0, block register=0, s_axis_tready=1 from the first cycle after reset, m_axis_tvalid=0, busy=0.
- Reset asserted mid-RUN or in DONE: the block is discarded, no output is produced, and the core is in IDLE the next cycle.
- A reset coincident with an input handshake also discards the block.

Test Plan:
- Encrypt 64'h0123_4567_89AB_CDEF with round_keys[i] = {16'h1111*i[3:0], 16'hA5A5, 16'h5A5A}, m_axis_tready=1. Expect the result to equal the team C reference model, with m_axis_tvalid rising exactly 33 cycles after the input handshake and lasting 1 cycle.
- Round trip: feed that ciphertext with decrypt=1 and the same keys. Expect m_axis_tdata == 64'h0123_4567_89AB_CDEF. Repeat for 100 random blocks and keys; all must match.
- Back-pressure: hold m_axis_tready=0 for 10 cycles in DONE. Expect tdata stable, tvalid=1, s_axis_tready=0 throughout. Release, then s_axis_tready=1 on the next cycle.
- All-zero keys and all-zero block: output equals the reference model. Verify the last round used round_keys[31] by corrupting only entry 31 and observing a changed result.
- Reset at round 17: expect m_axis_tvalid=0, s_axis_tready=1 on the cycle after reset. The next block encrypts correctly, with no leftover state.
- Back-to-back: hold s_axis_tvalid=1 continuously with m_axis_tready=1. Expect handshakes every 34 cycles and 3 correct outputs in order.
